// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad row scanner with press/release debounce; define KEYPAD_RELEASE_EVT_EN to enable key_release pulses
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sync_col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_release
);
  localparam int MAXP = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW = $clog2(MAXP) + 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // key codes packed by {row, col}, row 0 col 0 in the lowest nibble
  localparam logic [63:0] MAP = 64'hDF0E_C987_B654_A321;
`ifdef KEYPAD_RELEASE_EVT_EN
  localparam logic REL_EN = 1'b1;
`else
  localparam logic REL_EN = 1'b0;
`endif
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE_DB} state_t;
  state_t state;
  logic [1:0] r;
  logic [1:0] c;
  logic [1:0] low_idx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic one_low;
  logic col_up;
  assign row = ~(4'b0001 << r);
  // column decode and saturating counter increment
  always_comb begin
    one_low = $onehot(~sync_col);
    low_idx = !sync_col[0] ? 2'd0 : !sync_col[1] ? 2'd1 : !sync_col[2] ? 2'd2 : 2'd3;
    col_up  = sync_col[c];
    cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
  end
  // scan / debounce / hold / release-debounce sequencer with registered outputs
  always_ff @(posedge clk) begin
    key_valid   <= 1'b0;
    key_release <= 1'b0;
    if (!reset) begin
      state    <= SCAN;
      r        <= '0;
      c        <= '0;
      cnt      <= '0;
      key_code <= '0;
      key_held <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (cnt != SCAN_LAST) begin
            cnt <= cnt_inc;
          end else begin
            cnt <= '0;
            if (one_low) begin
              c     <= low_idx;
              state <= DEBOUNCE;
            end else begin
              r <= r + 1'b1;
            end
          end
        end
        DEBOUNCE: begin
          if (col_up) begin
            state <= SCAN;
            r     <= r + 1'b1;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            key_valid <= 1'b1;
            key_code  <= MAP[{r, c, 2'b00} +: 4];
            key_held  <= 1'b1;
            state     <= HELD;
            cnt       <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        HELD: begin
          if (col_up) begin
            state <= RELEASE_DB;
            cnt   <= '0;
          end
        end
        RELEASE_DB: begin
          if (!col_up) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            key_held    <= 1'b0;
            key_release <= REL_EN;
            state       <= SCAN;
            r           <= r + 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized and directed checks of keypad_scanner against a behavioural model
module tb_keypad_scanner;
  localparam int S = 4;
  localparam int D = 8;
`ifdef KEYPAD_RELEASE_EVT_EN
  localparam bit REL_ON = 1'b1;
`else
  localparam bit REL_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] sync_col = 4'hF;
  logic [3:0] row;
  logic [3:0] key_code;
  logic key_valid;
  logic key_held;
  logic key_release;
  int checks = 0;
  int failures = 0;
  keypad_scanner #(.SCAN_DIV(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .sync_col(sync_col), .row(row), .key_code(key_code),
    .key_valid(key_valid), .key_held(key_held), .key_release(key_release)
  );
  always #5 clk = ~clk;
  // keypad legend, row-major
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  // model: phase 0 scanning, 1 waiting for a stable press, 2 key down, 3 waiting for a stable release
  int m_phase = 0;
  int m_r = 0;
  int m_c = 0;
  int m_t = 0;
  logic [3:0] m_code = 4'h0;
  bit m_valid = 0;
  bit m_held = 0;
  bit m_rel = 0;
  task automatic model_step(input logic rs, input logic [3:0] col);
    m_valid = 0;
    m_rel = 0;
    if (!rs) begin
      m_phase = 0; m_r = 0; m_c = 0; m_t = 0; m_code = 4'h0; m_held = 0;
    end else if (m_phase == 0) begin
      if (m_t < S - 1) m_t++;
      else begin
        m_t = 0;
        if ($countones(~col) == 1) begin
          for (int k = 3; k >= 0; k--) if (!col[k]) m_c = k;
          m_phase = 1;
        end else m_r = (m_r + 1) % 4;
      end
    end else if (m_phase == 1) begin
      if (col[m_c]) begin
        m_phase = 0; m_r = (m_r + 1) % 4; m_t = 0;
      end else begin
        m_t++;
        if (m_t == D) begin
          m_valid = 1; m_code = keymap[m_r * 4 + m_c]; m_held = 1; m_phase = 2; m_t = 0;
        end
      end
    end else if (m_phase == 2) begin
      if (col[m_c]) begin m_phase = 3; m_t = 0; end
    end else begin
      if (!col[m_c]) begin m_phase = 2; m_t = 0; end
      else begin
        m_t++;
        if (m_t == D) begin
          m_held = 0; m_rel = REL_ON; m_phase = 0; m_r = (m_r + 1) % 4; m_t = 0;
        end
      end
    end
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // one clock: apply inputs, advance model at the edge, compare all outputs after it
  task automatic tick(input logic rs, input logic [3:0] col);
    logic [3:0] exp_row;
    reset = rs;
    sync_col = col;
    @(posedge clk);
    model_step(rs, col);
    #1;
    exp_row = 4'hF;
    exp_row[m_r] = 1'b0;
    chk("model", {21'd0, row, key_code, key_valid, key_held, key_release},
        {21'd0, exp_row, m_code, m_valid, m_held, m_rel});
  endtask
  int nv;
  int nr;
  logic [3:0] seen;
  logic [3:0] idle_rows [4] = '{4'hD, 4'hB, 4'h7, 4'hE};
  int kr, kc, press_left, gap_left;
  bit two;
  logic [3:0] col;
  initial begin
    tick(0, 4'hF);
    tick(0, 4'hF);
    chk("reset_row", {28'd0, row}, 32'hE);
    chk("reset_code", {28'd0, key_code}, 32'h0);
    chk("reset_flags", {29'd0, key_valid, key_held, key_release}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      repeat (S) tick(1, 4'hF);
      chk("idle_scan_row", {28'd0, row}, {28'd0, idle_rows[i]});
    end
    nv = 0;
    seen = 4'h0;
    for (int i = 0; i < 30; i++) begin
      tick(1, (row == 4'hD) ? 4'hB : 4'hF);
      if (key_valid) begin nv++; seen = key_code; end
    end
    chk("press6_pulses", nv, 1);
    chk("press6_code", {28'd0, seen}, 32'h6);
    chk("press6_held", {31'd0, key_held}, 1);
    chk("press6_row", {28'd0, row}, 32'hD);
    nr = 0;
    repeat (3) begin tick(1, 4'hF); nr += key_release; end
    repeat (3) begin tick(1, 4'hB); nr += key_release; end
    chk("glitch_held", {31'd0, key_held}, 1);
    chk("glitch_rel", nr, 0);
    repeat (12) begin tick(1, 4'hF); nr += key_release; end
    chk("release_held", {31'd0, key_held}, 0);
    chk("release_pulses", nr, REL_ON ? 1 : 0);
    chk("release_row", {28'd0, row}, 32'hB);
    nv = 0;
    repeat (4) begin tick(1, (row == 4'hB) ? 4'hE : 4'hF); nv += key_valid; end
    tick(1, 4'hF);
    nv += key_valid;
    chk("bounce_valid", nv, 0);
    chk("bounce_row", {28'd0, row}, 32'h7);
    repeat (4) tick(1, 4'hF);
    nv = 0;
    repeat (4) begin tick(1, 4'h9); nv += key_valid; end
    chk("double_valid", nv, 0);
    chk("double_row", {28'd0, row}, 32'hD);
    repeat (6) tick(1, 4'hB);
    tick(0, 4'hB);
    chk("midreset_row", {28'd0, row}, 32'hE);
    chk("midreset_code", {28'd0, key_code}, 32'h0);
    chk("midreset_flags", {29'd0, key_valid, key_held, key_release}, 32'h0);
    press_left = 0;
    gap_left = 0;
    kr = 0; kc = 0; two = 0;
    for (int i = 0; i < 4000; i++) begin
      if (press_left > 0) press_left--;
      else if (gap_left > 0) gap_left--;
      else begin
        kr = $urandom % 4;
        kc = $urandom % 4;
        two = ($urandom % 5) == 0;
        press_left = $urandom_range(5, 80);
        gap_left = $urandom_range(0, 30);
      end
      col = 4'hF;
      if (press_left > 0 && row[kr] == 1'b0) begin
        col[kc] = 1'b0;
        if (two) col[(kc + 1) % 4] = 1'b0;
      end
      if ($urandom % 25 == 0) col[$urandom % 4] ^= 1'b1;
      tick(($urandom % 500) != 0, col);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
